// File: rtl/seven_seg_capture_pkg.sv
// Shared seven-segment constants for the capture block and display decoders.
// Patterns are active-low, bit0=a .. bit6=g.
package seven_seg_capture_pkg;

  localparam logic [6:0] PAT_0 = 7'h40;
  localparam logic [6:0] PAT_1 = 7'h79;
  localparam logic [6:0] PAT_2 = 7'h24;
  localparam logic [6:0] PAT_3 = 7'h30;
  localparam logic [6:0] PAT_4 = 7'h19;
  localparam logic [6:0] PAT_5 = 7'h12;
  localparam logic [6:0] PAT_6 = 7'h02;
  localparam logic [6:0] PAT_7 = 7'h78;
  localparam logic [6:0] PAT_8 = 7'h00;
  localparam logic [6:0] PAT_9 = 7'h10;

  localparam logic [6:0] BLANK_PAT      = 7'h7F;
  localparam logic [3:0] BLANK_NIBBLE   = 4'hF;
  localparam logic [3:0] INVALID_NIBBLE = 4'hE;

  localparam logic [2:0] AN_IDLE = 3'b111;
  localparam logic [2:0] FULL_MASK = 3'b111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational pattern-to-nibble decoder.
// Unknown patterns map to INVALID_NIBBLE with invalid raised.
module seg7_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       invalid
);

  always_comb begin
    nibble  = INVALID_NIBBLE;
    invalid = 1'b0;
    case (pat)
      PAT_0:     nibble = 4'h0;
      PAT_1:     nibble = 4'h1;
      PAT_2:     nibble = 4'h2;
      PAT_3:     nibble = 4'h3;
      PAT_4:     nibble = 4'h4;
      PAT_5:     nibble = 4'h5;
      PAT_6:     nibble = 4'h6;
      PAT_7:     nibble = 4'h7;
      PAT_8:     nibble = 4'h8;
      PAT_9:     nibble = 4'h9;
      BLANK_PAT: nibble = BLANK_NIBBLE;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Debounces a multiplexed 3-digit display bus and
// publishes complete frames with a one-cycle VALID.
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  SEG,
  input  logic [2:0]  AN,
  output logic [11:0] D,
  output logic        VALID,
  output logic [2:0]  ERR
);

  localparam int CW = 4;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  logic [2:0]    prev_an;
  logic [6:0]    prev_seg;
  logic [CW-1:0] run;
  logic [CW-1:0] run_next;
  logic [2:0]    mask;
  logic [2:0]    mask_next;
  logic [11:0]   slots;
  logic [2:0]    flags;
  logic          one_hot;
  logic [1:0]    idx;
  logic          accept;
  logic          full;
  logic [2:0]    sel;
  logic [3:0]    nib;
  logic          inv;

  seg7_decode u_dec (
    .pat     (SEG),
    .nibble  (nib),
    .invalid (inv)
  );

  always_comb begin
    one_hot = 1'b0;
    idx     = 2'd0;
    unique case (1'b1)
      AN == 3'b110: begin one_hot = 1'b1; idx = 2'd0; end
      AN == 3'b101: begin one_hot = 1'b1; idx = 2'd1; end
      AN == 3'b011: begin one_hot = 1'b1; idx = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    run_next = '0;
    if (one_hot) begin
      if (AN == prev_an && SEG == prev_seg)
        run_next = (run == STABLE_C) ? run : run + 1'b1;
      else
        run_next = CW'(1);
    end
  end

  // Only the edge where the run first hits STABLE accepts.
  assign accept    = one_hot && run_next == STABLE_C &&
                     run != STABLE_C;
  assign full      = mask == FULL_MASK;
  assign sel       = accept ? ~AN : 3'b000;
  assign mask_next = (full ? 3'b000 : mask) | sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_an  <= AN_IDLE;
      prev_seg <= BLANK_PAT;
      run      <= '0;
      mask     <= '0;
      slots    <= '0;
      flags    <= '0;
      D        <= '0;
      ERR      <= '0;
      VALID    <= 1'b0;
    end else begin
      run   <= run_next;
      mask  <= mask_next;
      VALID <= full;
      if (one_hot) begin
        prev_an  <= AN;
        prev_seg <= SEG;
      end
      if (full) begin
        D   <= slots;
        ERR <= flags;
      end
      if (accept) begin
        slots[{idx, 2'b00} +: 4] <= nib;
        flags[idx]               <= inv;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (STABLE=4):
// table of full frames plus hand-written corner sequences.
module tb_seven_seg_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  SEG;
  logic [2:0]  AN;
  logic [11:0] D;
  logic        VALID;
  logic [2:0]  ERR;

  int tests;
  int fails;
  int vcnt;
  int base;

  typedef struct {
    logic [6:0]  s0;
    logic [6:0]  s1;
    logic [6:0]  s2;
    logic [11:0] d;
    logic [2:0]  err;
  } vec_t;

  vec_t tbl [6];

  seven_seg_capture #(.STABLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SEG   (SEG),
    .AN    (AN),
    .D     (D),
    .VALID (VALID),
    .ERR   (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial vcnt = 0;
  always @(negedge clk) if (VALID === 1'b1) vcnt = vcnt + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the pair for n sampling edges.
  task automatic hold(input logic [2:0] a, input logic [6:0] s,
                      input int n);
    AN  = a;
    SEG = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    hold(3'b111, 7'h7F, n);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2);
    hold(3'b110, s0, 4);
    hold(3'b101, s1, 4);
    hold(3'b011, s2, 4);
    idle(3);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tbl[0] = '{7'h30, 7'h02, 7'h79, 12'h163, 3'b000};
    tbl[1] = '{7'h40, 7'h7E, 7'h7F, 12'hFE0, 3'b010};
    tbl[2] = '{7'h78, 7'h00, 7'h10, 12'h987, 3'b000};
    tbl[3] = '{7'h12, 7'h19, 7'h24, 12'h245, 3'b000};
    tbl[4] = '{7'h7F, 7'h7F, 7'h7F, 12'hFFF, 3'b000};
    tbl[5] = '{7'h01, 7'h7E, 7'h41, 12'hEEE, 3'b111};

    rst_n = 1'b0;
    AN    = 3'b111;
    SEG   = 7'h7F;
    #1;
    chk("reset_D", 32'(D), 32'h0);
    chk("reset_ERR", 32'(ERR), 32'h0);
    chk("reset_VALID", 32'(VALID), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      base = vcnt;
      frame(tbl[i].s0, tbl[i].s1, tbl[i].s2);
      chk($sformatf("tbl%0d_D", i), 32'(D), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_ERR", i), 32'(ERR), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_pulses", i), 32'(vcnt - base), 32'd1);
    end

    // Reset mid-frame discards digits 2 and 1.
    hold(3'b011, 7'h10, 4);
    hold(3'b101, 7'h00, 4);
    AN    = 3'b111;
    SEG   = 7'h7F;
    rst_n = 1'b0;
    #1;
    chk("midrst_D", 32'(D), 32'h0);
    chk("midrst_ERR", 32'(ERR), 32'h0);
    chk("midrst_VALID", 32'(VALID), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    base = vcnt;
    hold(3'b110, 7'h78, 4);
    idle(4);
    chk("midrst_partial_pulses", 32'(vcnt - base), 32'd0);
    chk("midrst_partial_D", 32'(D), 32'h0);
    hold(3'b101, 7'h00, 4);
    hold(3'b011, 7'h10, 4);
    idle(3);
    chk("midrst_D_987", 32'(D), 32'h987);
    chk("midrst_pulses", 32'(vcnt - base), 32'd1);

    // VALID arrives exactly STABLE+1 edges after digit 2 starts.
    base = vcnt;
    hold(3'b110, 7'h30, 4);
    hold(3'b101, 7'h30, 4);
    AN  = 3'b011;
    SEG = 7'h30;
    repeat (4) @(negedge clk);
    chk("lat_not_yet", 32'(VALID), 32'h0);
    @(negedge clk);
    chk("lat_valid", 32'(VALID), 32'h1);
    idle(2);
    chk("lat_D", 32'(D), 32'h333);
    chk("lat_pulses", 32'(vcnt - base), 32'd1);

    // A 3-sample run is never accepted.
    base = vcnt;
    hold(3'b110, 7'h24, 3);
    hold(3'b101, 7'h02, 4);
    hold(3'b011, 7'h79, 4);
    idle(3);
    chk("short_no_valid", 32'(vcnt - base), 32'd0);
    chk("short_D_held", 32'(D), 32'h333);
    hold(3'b110, 7'h24, 4);
    idle(3);
    chk("short_then_ok_pulses", 32'(vcnt - base), 32'd1);
    chk("short_then_ok_D", 32'(D), 32'h162);

    // Re-acceptance of digit 0 overwrites its slot.
    base = vcnt;
    hold(3'b110, 7'h40, 4);
    hold(3'b110, 7'h79, 4);
    hold(3'b101, 7'h24, 4);
    hold(3'b011, 7'h30, 4);
    idle(3);
    chk("overwrite_D", 32'(D), 32'h321);
    chk("overwrite_ERR", 32'(ERR), 32'h0);
    chk("overwrite_pulses", 32'(vcnt - base), 32'd1);

    // Illegal enables and long holds.
    base = vcnt;
    hold(3'b100, 7'h00, 10);
    hold(3'b110, 7'h00, 20);
    idle(3);
    chk("long_no_valid", 32'(vcnt - base), 32'd0);
    hold(3'b101, 7'h40, 4);
    hold(3'b011, 7'h40, 4);
    idle(3);
    chk("long_D", 32'(D), 32'h008);
    chk("long_pulses", 32'(vcnt - base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
